// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int AWAIT_CNT_W = 8;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_AWAIT   = 2'd1;
    localparam state_t ST_BUSY    = 2'd2;
    localparam state_t ST_RELEASE = 2'd3;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_DMA = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection; round-robin on ties when MEM_ARB_RR_EN is
// defined, otherwise fixed CPU priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   cpu_req,
    input  logic   dma_req,
    input  owner_e last_grant,
    output owner_e winner
);

    always_comb begin
        // NOTE: default first so every path assigns winner and no latch is inferred.
        winner = last_grant;
        if (cpu_req && dma_req) begin
`ifdef MEM_ARB_RR_EN
            winner = (last_grant == OWNER_CPU) ? OWNER_DMA : OWNER_CPU;
`else
            winner = OWNER_CPU;
`endif
        end else if (cpu_req) begin
            winner = OWNER_CPU;
        end else if (dma_req) begin
            winner = OWNER_DMA;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU and a radio DMA onto one shared memory port.
// Define MEM_ARB_RR_EN for round-robin tie breaking; default is fixed CPU priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AWAIT_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        cpu_ce_n,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_busy,
    output logic        cpu_valid,
    output logic [31:0] cpu_rdata,

    input  logic        dma_ce_n,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_busy,
    output logic        dma_valid,
    output logic [31:0] dma_rdata,

    output logic        mem_ce_n,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_busy,
    input  logic        mem_valid,
    input  logic [31:0] mem_rdata,

    output logic        grant_cpu,
    output logic        grant_dma,
    output logic        timeout_err
);

    localparam logic [AWAIT_CNT_W-1:0] TIMEOUT_LAST = AWAIT_CNT_W'(AWAIT_TIMEOUT - 1);

    state_t                 state, state_nxt;
    owner_e                 owner, winner, last_grant;
    logic [AWAIT_CNT_W-1:0] await_cnt;
    logic                   any_req, active;
    logic                   own_ce_n, own_we;
    logic [31:0]            own_addr, own_wdata;
    logic                   cpu_sel, dma_sel;

    assign any_req = !cpu_ce_n || !dma_ce_n;

    mem_arb_pick u_pick (
        .cpu_req    (!cpu_ce_n),
        .dma_req    (!dma_ce_n),
        .last_grant (last_grant),
        .winner     (winner)
    );

`ifdef MEM_ARB_RR_EN
    // Resets to DMA so the first tie after reset goes to the CPU.
    always_ff @(posedge clk) begin
        if (reset)
            last_grant <= OWNER_DMA;
        else if (state == ST_IDLE && any_req)
            last_grant <= winner;
    end
`else
    assign last_grant = OWNER_DMA;
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state     <= ST_IDLE;
            owner     <= OWNER_CPU;
            await_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && any_req)
                owner <= winner;
            await_cnt <= (state == ST_AWAIT && state_nxt == ST_AWAIT) ?
                         await_cnt + 1'b1 : '0;
        end
    end

    assign own_ce_n  = (owner == OWNER_CPU) ? cpu_ce_n  : dma_ce_n;
    assign own_we    = (owner == OWNER_CPU) ? cpu_we    : dma_we;
    assign own_addr  = (owner == OWNER_CPU) ? cpu_addr  : dma_addr;
    assign own_wdata = (owner == OWNER_CPU) ? cpu_wdata : dma_wdata;

    always_comb begin
        state_nxt   = state;
        timeout_err = 1'b0;
        case (state)
            ST_IDLE:
                if (any_req) state_nxt = ST_AWAIT;
            ST_AWAIT:
                if (own_ce_n) begin
                    state_nxt = ST_RELEASE;
                end else if (mem_busy) begin
                    state_nxt = ST_BUSY;
                end else if (await_cnt == TIMEOUT_LAST) begin
                    state_nxt   = ST_RELEASE;
                    timeout_err = 1'b1;
                end
            ST_BUSY:
                if (own_ce_n || !mem_busy) state_nxt = ST_RELEASE;
            ST_RELEASE:
                // Waiting for ce_n high keeps a held request from being re-granted.
                if (own_ce_n) state_nxt = ST_IDLE;
            default:
                state_nxt = ST_IDLE;
        endcase
    end

    assign active    = (state == ST_AWAIT) || (state == ST_BUSY);
    assign mem_ce_n  = active ? own_ce_n  : 1'b1;
    assign mem_we    = active & own_we;
    assign mem_addr  = active ? own_addr  : 32'h0;
    assign mem_wdata = active ? own_wdata : 32'h0;

    assign cpu_sel   = active && (owner == OWNER_CPU);
    assign dma_sel   = active && (owner == OWNER_DMA);
    assign cpu_busy  = cpu_sel & mem_busy;
    assign cpu_valid = cpu_sel & mem_valid;
    assign cpu_rdata = cpu_sel ? mem_rdata : 32'h0;
    assign dma_busy  = dma_sel & mem_busy;
    assign dma_valid = dma_sel & mem_valid;
    assign dma_rdata = dma_sel ? mem_rdata : 32'h0;

    assign grant_cpu = (state != ST_IDLE) && (owner == OWNER_CPU);
    assign grant_dma = (state != ST_IDLE) && (owner == OWNER_DMA);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (AWAIT_TIMEOUT=4); tie
// expectations follow MEM_ARB_RR_EN.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_ce_n, cpu_we, dma_ce_n, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic        cpu_busy, cpu_valid, dma_busy, dma_valid;
    logic [31:0] cpu_rdata, dma_rdata;
    logic        mem_ce_n, mem_we, mem_busy, mem_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        grant_cpu, grant_dma, timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.AWAIT_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_ce_n(cpu_ce_n), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_busy(cpu_busy), .cpu_valid(cpu_valid), .cpu_rdata(cpu_rdata),
        .dma_ce_n(dma_ce_n), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_busy(dma_busy), .dma_valid(dma_valid), .dma_rdata(dma_rdata),
        .mem_ce_n(mem_ce_n), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_busy(mem_busy), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
        .grant_cpu(grant_cpu), .grant_dma(grant_dma), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1;
        cpu_ce_n = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_ce_n = 1'b1; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        mem_busy = 1'b0; mem_valid = 1'b0; mem_rdata = '0;

        // Reset state
        cyc(); cyc(); settle();
        check("rst_grant_cpu", grant_cpu, 0);
        check("rst_grant_dma", grant_dma, 0);
        check("rst_mem_ce_n", mem_ce_n, 1);
        check("rst_timeout", timeout_err, 0);
        check("rst_busy", {cpu_busy, cpu_valid, dma_busy, dma_valid}, 0);

        // CPU-only read, then owner holds ce_n low in RELEASE
        reset = 1'b0;
        cpu_ce_n = 1'b0; cpu_addr = 32'h100; settle();
        check("idle_no_grant", grant_cpu, 0);
        check("idle_mem_ce_n", mem_ce_n, 1);
        cyc(); mem_busy = 1'b1; settle();
        check("rd_grant_cpu", grant_cpu, 1);
        check("rd_mem_addr", mem_addr, 32'h100);
        check("rd_mem_ce_n", mem_ce_n, 0);
        check("rd_cpu_busy", cpu_busy, 1);
        check("rd_dma_busy_a", dma_busy, 0);
        cyc(); settle();
        check("rd_cpu_busy2", cpu_busy, 1);
        check("rd_dma_busy_b", dma_busy, 0);
        cyc(); settle();
        cyc(); mem_busy = 1'b0; mem_valid = 1'b1; mem_rdata = 32'hDEADBEEF; settle();
        check("rd_cpu_valid", cpu_valid, 1);
        check("rd_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        check("rd_dma_valid", dma_valid, 0);
        check("rd_dma_rdata", dma_rdata, 0);
        cyc(); mem_valid = 1'b0; mem_rdata = '0; settle();
        check("rel_mem_ce_n", mem_ce_n, 1);
        check("rel_mem_addr", mem_addr, 0);
        check("rel_grant", grant_cpu, 1);
        for (int i = 0; i < 2; i++) begin
            cyc(); settle();
            check("hold_mem_ce_n", mem_ce_n, 1);
            check("hold_grant", grant_cpu, 1);
        end
        cpu_ce_n = 1'b1;
        cyc(); settle();
        check("hold_to_idle", grant_cpu, 0);
        cyc(); settle();
        check("idle_stays", {grant_cpu, grant_dma, mem_ce_n}, 3'b001);

        // Simultaneous request, twice, starting from a fresh reset
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cpu_ce_n = 1'b0; dma_ce_n = 1'b0; cpu_addr = 32'h400; dma_addr = 32'h500;
        cyc(); settle();
        check("tie1_grant_cpu", grant_cpu, 1);
        check("tie1_grant_dma", grant_dma, 0);
        check("tie1_mem_addr", mem_addr, 32'h400);
        mem_busy = 1'b1; cyc();
        mem_busy = 1'b0; cyc();
        cpu_ce_n = 1'b1; dma_ce_n = 1'b1; cyc();
        cpu_ce_n = 1'b0; dma_ce_n = 1'b0;
        cyc(); settle();
`ifdef MEM_ARB_RR_EN
        check("tie2_grant", {grant_cpu, grant_dma}, 2'b01);
        check("tie2_mem_addr", mem_addr, 32'h500);
`else
        check("tie2_grant", {grant_cpu, grant_dma}, 2'b10);
        check("tie2_mem_addr", mem_addr, 32'h400);
`endif
        mem_busy = 1'b1; cyc();
        mem_busy = 1'b0; cyc();
        cpu_ce_n = 1'b1; dma_ce_n = 1'b1; cyc();

        // DMA owns the port, CPU requests mid-transfer
        dma_ce_n = 1'b0; dma_addr = 32'h200; dma_we = 1'b1; dma_wdata = 32'hCAFE0001;
        cyc(); mem_busy = 1'b1; settle();
        check("dma_grant", grant_dma, 1);
        check("dma_mem_addr", mem_addr, 32'h200);
        check("dma_mem_we", mem_we, 1);
        check("dma_mem_wdata", mem_wdata, 32'hCAFE0001);
        cyc(); cpu_ce_n = 1'b0; cpu_addr = 32'h300; settle();
        check("held_cpu_busy", cpu_busy, 0);
        check("held_grant_cpu", grant_cpu, 0);
        check("held_mem_addr", mem_addr, 32'h200);
        cyc(); settle();
        check("held_mem_addr2", mem_addr, 32'h200);
        mem_busy = 1'b0; mem_valid = 1'b1; mem_rdata = 32'h12345678; settle();
        check("dma_valid", dma_valid, 1);
        check("held_cpu_valid", cpu_valid, 0);
        cyc(); mem_valid = 1'b0; mem_rdata = '0; dma_ce_n = 1'b1; dma_we = 1'b0; settle();
        check("dma_rel_addr", mem_addr, 0);
        check("dma_rel_cpu_busy", cpu_busy, 0);
        check("dma_rel_grant_cpu", grant_cpu, 0);
        cyc(); settle();
        check("gap_idle", {grant_cpu, grant_dma}, 2'b00);
        cyc(); settle();
        check("cpu_after_dma", grant_cpu, 1);
        check("cpu_after_addr", mem_addr, 32'h300);

        // Memory never responds: timeout in the 4th AWAIT cycle
        check("to_await1", timeout_err, 0);
        cyc(); cyc(); settle();
        check("to_await3", timeout_err, 0);
        cyc(); settle();
        check("to_pulse", timeout_err, 1);
        check("to_pulse_ce_n", mem_ce_n, 0);
        cyc(); settle();
        check("to_after", timeout_err, 0);
        check("to_after_ce_n", mem_ce_n, 1);
        cpu_ce_n = 1'b1; cyc();

        // Owner aborts during BUSY
        cpu_ce_n = 1'b0; cyc();
        mem_busy = 1'b1; cyc();
        cpu_ce_n = 1'b1; settle();
        check("abort_ce_n_now", mem_ce_n, 1);
        cyc(); mem_busy = 1'b0; settle();
        check("abort_rel", {grant_cpu, mem_ce_n}, 2'b11);
        cyc(); settle();
        check("abort_idle", grant_cpu, 0);

        // Reset asserted in BUSY
        dma_ce_n = 1'b0; cyc();
        mem_busy = 1'b1; cyc(); settle();
        check("pre_rst_dma_busy", dma_busy, 1);
        reset = 1'b1;
        cyc(); settle();
        check("mid_rst_grants", {grant_cpu, grant_dma}, 2'b00);
        check("mid_rst_ce_n", mem_ce_n, 1);
        check("mid_rst_dma_busy", dma_busy, 0);
        reset = 1'b0; dma_ce_n = 1'b1; mem_busy = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AWAIT_TIMEOUT, default 15: maximum cycles in AWAIT without mem_busy before abandoning the grant; legal range 1..255.
REQ-002 clk  in  1  clock; all logic on posedge.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 cpu_ce_n / cpu_we / cpu_addr / cpu_wdata  in  1/1/32/32  CPU request; ce_n held low for the whole access.
REQ-005 cpu_busy / cpu_valid / cpu_rdata  out  1/1/32  memory response routed to the CPU.
REQ-006 dma_ce_n / dma_we / dma_addr / dma_wdata  in  1/1/32/32  radio DMA request; same protocol as CPU.
REQ-007 dma_busy / dma_valid / dma_rdata  out  1/1/32  memory response routed to the DMA.
REQ-008 mem_ce_n / mem_we / mem_addr / mem_wdata  out  1/1/32/32  shared memory port.
REQ-009 mem_busy / mem_valid / mem_rdata  in  1/1/32  shared memory response.
REQ-010 grant_cpu / grant_dma  out  1/1  current owner, one-hot or both 0.
REQ-011 timeout_err  out  1  one-cycle pulse on an AWAIT timeout.

Function
REQ-012 FSM states: IDLE, AWAIT, BUSY, RELEASE; registered, next-state combinational.
REQ-013 IDLE: if any ce_n is low, latch the winner into the owner register and go to AWAIT next cycle; otherwise stay in IDLE.
REQ-014 Arbitration: with only one requester active, that requester wins; on a simultaneous request the winner is chosen per REQ-024.
REQ-015 AWAIT/BUSY: mem_ce_n, mem_we, mem_addr and mem_wdata come combinationally from the owner's inputs; owner busy/valid/rdata = mem_busy/mem_valid/mem_rdata.
REQ-016 The non-owner's busy and valid are 0 and its rdata is 0 in every state, so a waiting requester stays in its own await state.
REQ-017 AWAIT -> BUSY when mem_busy=1; the await counter clears on entry to AWAIT and increments each AWAIT cycle.
REQ-018 AWAIT -> RELEASE when the counter reaches AWAIT_TIMEOUT with mem_busy=0; timeout_err=1 for exactly that transition cycle.
REQ-019 BUSY -> RELEASE when mem_busy=0; mem_valid in that cycle reaches the owner unchanged.
REQ-020 RELEASE: mem_ce_n=1; stay until the owner's ce_n=1, then go to IDLE and clear the grant, so a stale held request is never re-granted.
REQ-021 Owner ce_n rising during AWAIT or BUSY (abort): go to RELEASE immediately; mem_ce_n rises in the same cycle.
REQ-022 Outside AWAIT/BUSY: mem_ce_n=1, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-023 Minimum turnaround is IDLE->AWAIT in 1 cycle and RELEASE->IDLE in 1 cycle; back-to-back grants are spaced at least 1 IDLE cycle apart.

Configuration
REQ-024 Macro MEM_ARB_RR_EN defined: on a simultaneous request, the winner is the requester not granted last; the last-granted register resets to DMA, so the first tie goes to the CPU.
REQ-025 MEM_ARB_RR_EN undefined: fixed priority, CPU always wins ties; no last-granted register is synthesised.

Reset
REQ-026 In the cycle after reset: state=IDLE, grants=0, counter=0, timeout_err=0, mem_ce_n=1, all busy/valid outputs 0.
REQ-027 Reset mid-transaction abandons the access immediately; the memory side sees mem_ce_n=1 on the next edge.

Structure
REQ-028 Package mem_arb_pkg: state enum, owner enum (OWNER_CPU, OWNER_DMA), and the AWAIT_TIMEOUT width constant (8).
REQ-029 One combinational sub-module, mem_arb_pick: takes both requests and the last grant, returns the winner; the RR/fixed selection is compiled inside it.

Verification
REQ-030 CPU-only read: cpu_ce_n=0 addr 0x100; memory busy 3 cycles, rdata 0xDEADBEEF -> grant_cpu=1, cpu_valid with 0xDEADBEEF, dma_busy=0 throughout.
REQ-031 Simultaneous request in the same cycle, run twice: fixed build -> CPU, CPU; MEM_ARB_RR_EN build -> CPU then DMA.
REQ-032 DMA owns the port, CPU requests mid-transfer -> CPU held (cpu_busy=0) until DMA RELEASE->IDLE, then granted; mem_addr never mixes owners.
REQ-033 Memory never asserts busy, AWAIT_TIMEOUT=4 -> timeout_err pulses in the 4th AWAIT cycle and mem_ce_n=1 next cycle.
REQ-034 Owner holds ce_n low 3 cycles after completion -> stays in RELEASE, no second access, IDLE one cycle after ce_n rises.
REQ-035 Reset asserted in BUSY -> next cycle IDLE, grants 0, mem_ce_n=1.
